// File: rtl/sound_sequencer_if.sv
// Bus between game logic and the sound sequencer: frame sync and event pulses in,
// tone-generator controls and status out.
interface sound_sequencer_if;
  logic       vsync;
  logic       failure;
  logic       success;
  logic       eat;
  logic       tick;
  logic [7:0] tone_period;
  logic       tone_en;
  logic       tone_restart;
  logic       busy;
  logic [1:0] cur_event;

  modport master (
    output vsync, failure, success, eat, tick,
    input  tone_period, tone_en, tone_restart, busy, cur_event
  );

  modport slave (
    input  vsync, failure, success, eat, tick,
    output tone_period, tone_en, tone_restart, busy, cur_event
  );
endinterface

// File: rtl/sound_sequencer.sv
// Latches game sound events, arbitrates them by fixed priority and plays each as a
// short note sequence on the square-wave tone generator, one note per frame window.
module sound_sequencer #(
  parameter int NOTE_FRAMES = 6,
  parameter int TICK_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sound_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [3:0] NOTE_LAST = 4'(NOTE_FRAMES - 1);
  localparam logic [3:0] TICK_LAST = 4'(TICK_FRAMES - 1);

  state_t     state_reg, state_next;
  logic [3:0] pending_reg, pending_next;
  logic [1:0] note_idx_reg, note_idx_next;
  logic [3:0] frame_cnt_reg, frame_cnt_next;
  logic [7:0] period_reg, period_next;
  logic [1:0] cur_reg, cur_next;
  logic       en_reg, en_next;
  logic       restart_reg, restart_next;
  logic       busy_reg;
  logic       prev_vsync_reg;

  logic       fs;
  logic       tick_ok;
  logic       load;
  logic [1:0] hi_idx;
  logic [3:0] arrive;
  logic [3:0] clr_mask;
  logic [3:0] last_frame;
  logic [1:0] last_note;

  function automatic logic [7:0] note_rom(input logic [1:0] ev, input logic [1:0] idx);
    logic [7:0] p;
    case ({ev, idx})
      4'hC:    p = 8'd150;
      4'hD:    p = 8'd180;
      4'hE:    p = 8'd220;
      4'hF:    p = 8'd250;
      4'h8:    p = 8'd250;
      4'h9:    p = 8'd200;
      4'hA:    p = 8'd150;
      4'hB:    p = 8'd100;
      4'h4:    p = 8'd200;
      4'h5:    p = 8'd120;
      default: p = 8'd100;
    endcase
    return p;
  endfunction

  assign fs = bus.vsync & ~prev_vsync_reg;

  // A tick is only worth keeping when nothing else is playing, queued or arriving.
  assign tick_ok = bus.tick && (state_reg == IDLE) && (pending_reg == 4'd0)
                   && !(bus.failure || bus.success || bus.eat);
  assign arrive  = {bus.failure, bus.success, bus.eat, tick_ok};

  always_comb begin
    hi_idx = 2'd0;
    if (pending_reg[3])      hi_idx = 2'd3;
    else if (pending_reg[2]) hi_idx = 2'd2;
    else if (pending_reg[1]) hi_idx = 2'd1;
  end

  // Loading from IDLE, or preempting a strictly lower-priority sequence.
  assign load = (pending_reg != 4'd0) && ((state_reg == IDLE) || (hi_idx > cur_reg));

  // Loading any non-tick event also discards a queued tick.
  for (genvar gi = 0; gi < 4; gi++) begin : g_clr
    assign clr_mask[gi] = load && ((hi_idx == 2'(gi)) || (gi == 0 && hi_idx != 2'd0));
  end

  assign last_frame = (cur_reg == 2'd0) ? TICK_LAST : NOTE_LAST;
  assign last_note  = (cur_reg == 2'd0) ? 2'd0 : (cur_reg == 2'd1) ? 2'd1 : 2'd3;

  always_comb begin
    state_next     = state_reg;
    pending_next   = (pending_reg & ~clr_mask) | arrive;
    note_idx_next  = note_idx_reg;
    frame_cnt_next = frame_cnt_reg;
    period_next    = period_reg;
    en_next        = en_reg;
    restart_next   = 1'b0;
    cur_next       = cur_reg;
    if (load) begin
      note_idx_next  = 2'd0;
      frame_cnt_next = 4'd0;
      period_next    = note_rom(hi_idx, 2'd0);
      en_next        = 1'b1;
      restart_next   = 1'b1;
      cur_next       = hi_idx;
      state_next     = PLAY;
    end else if (fs) begin
      case (state_reg)
        PLAY: begin
          if (frame_cnt_reg == last_frame) begin
            en_next        = 1'b0;
            frame_cnt_next = 4'd0;
            state_next     = GAP;
          end else begin
            frame_cnt_next = frame_cnt_reg + 4'd1;
          end
        end
        GAP: begin
          if (note_idx_reg != last_note) begin
            note_idx_next  = note_idx_reg + 2'd1;
            period_next    = note_rom(cur_reg, note_idx_reg + 2'd1);
            en_next        = 1'b1;
            restart_next   = 1'b1;
            frame_cnt_next = 4'd0;
            state_next     = PLAY;
          end else begin
            cur_next   = 2'd0;
            state_next = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pending_reg    <= 4'd0;
      note_idx_reg   <= 2'd0;
      frame_cnt_reg  <= 4'd0;
      period_reg     <= 8'd0;
      cur_reg        <= 2'd0;
      en_reg         <= 1'b0;
      restart_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      prev_vsync_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      note_idx_reg   <= note_idx_next;
      frame_cnt_reg  <= frame_cnt_next;
      period_reg     <= period_next;
      cur_reg        <= cur_next;
      en_reg         <= en_next;
      restart_reg    <= restart_next;
      busy_reg       <= (state_next != IDLE);
      prev_vsync_reg <= bus.vsync;
    end
  end

  assign bus.tone_period  = period_reg;
  assign bus.tone_en      = en_reg;
  assign bus.tone_restart = restart_reg;
  assign bus.busy         = busy_reg;
  assign bus.cur_event    = cur_reg;

endmodule

// File: tb/tb_sound_sequencer.sv
// Random and directed stimulus for sound_sequencer; a frame-level reference model predicts
// every note start, and a monitor matches DUT note starts and status against it.
module tb_sound_sequencer;

  localparam int NOTE_FRAMES = 6;
  localparam int TICK_FRAMES = 4;
  localparam int FRAME       = 8;

  typedef struct {
    int ev;
    int per;
    int cyc;
  } note_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sound_sequencer_if bus();

  sound_sequencer #(.NOTE_FRAMES(NOTE_FRAMES), .TICK_FRAMES(TICK_FRAMES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input int req);
    n_vec++;
    if (act !== 32'(req)) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: each sequence is a queue of periods; a note lasts a number of frames
  // counted down from its duration, followed by one silent frame.
  note_t exp_q[$];
  int    cyc = 0;
  bit    m_pend[4];
  int    m_cur = -1;
  int    m_left = 0;
  int    m_per = 0;
  bit    m_gap = 1'b0;
  bit    m_en = 1'b0;
  bit    m_prev_vs = 1'b0;
  int    m_notes[$];

  task automatic m_load(input int ev);
    case (ev)
      3:       m_notes = '{150, 180, 220, 250};
      2:       m_notes = '{250, 200, 150, 100};
      1:       m_notes = '{200, 120};
      default: m_notes = '{100};
    endcase
  endtask

  task automatic m_start_note(input int ev);
    m_per  = m_notes.pop_front();
    m_cur  = ev;
    m_left = (ev == 0) ? TICK_FRAMES : NOTE_FRAMES;
    m_gap  = 1'b0;
    m_en   = 1'b1;
    exp_q.push_back('{ev, m_per, cyc});
  endtask

  function automatic bit m_any_pend();
    return m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      m_cur = -1; m_en = 1'b0; m_gap = 1'b0; m_prev_vs = 1'b0; m_per = 0;
      m_notes.delete();
      exp_q.delete();
    end else begin
      bit fs, tick_ok;
      int best;
      cyc++;
      fs = bus.vsync && !m_prev_vs;
      m_prev_vs = bus.vsync;
      tick_ok = bus.tick && m_cur < 0 && !m_any_pend() && !(bus.failure || bus.success || bus.eat);
      best = -1;
      for (int i = 0; i < 4; i++) if (m_pend[i]) best = i;
      if (best > m_cur) begin
        m_pend[best] = 1'b0;
        if (best > 0) m_pend[0] = 1'b0;
        m_load(best);
        m_start_note(best);
      end else if (m_cur >= 0 && fs) begin
        if (!m_gap) begin
          m_left--;
          if (m_left == 0) begin
            m_gap = 1'b1;
            m_en  = 1'b0;
          end
        end else if (m_notes.size() > 0) begin
          m_start_note(m_cur);
        end else begin
          m_cur = -1;
        end
      end
      if (bus.failure) m_pend[3] = 1'b1;
      if (bus.success) m_pend[2] = 1'b1;
      if (bus.eat)     m_pend[1] = 1'b1;
      if (tick_ok)     m_pend[0] = 1'b1;
    end
  end

  // Monitor: status every cycle, and a scoreboard pop on every note start the DUT announces.
  bit mon_on = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_on) begin
      check("busy", bus.busy, (m_cur >= 0) ? 1 : 0);
      check("tone_en", bus.tone_en, m_en ? 1 : 0);
      check("cur_event", bus.cur_event, (m_cur < 0) ? 0 : m_cur);
      if (m_en) check("tone_period", bus.tone_period, m_per);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_vec++; n_err++;
        $display("FAIL missing_restart: got none, want note ev=%0d period=%0d at cycle %0d",
                 exp_q[0].ev, exp_q[0].per, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.tone_restart === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_restart: got restart at cycle %0d, want none", cyc);
        end else begin
          note_t e;
          e = exp_q.pop_front();
          check("note_event", bus.cur_event, e.ev);
          check("note_period", bus.tone_period, e.per);
          check("note_cycle", 32'(cyc), e.cyc);
        end
      end else if (bus.tone_restart !== 1'b0) begin
        check("restart_known", bus.tone_restart, 0);
      end
    end
  end

  int vs_ph = 0;
  bit vs_hold = 1'b0;

  task automatic step(input bit f, input bit s, input bit e, input bit t);
    @(negedge clk);
    bus.failure = f;
    bus.success = s;
    bus.eat     = e;
    bus.tick    = t;
    vs_ph       = (vs_ph + 1) % FRAME;
    bus.vsync   = vs_hold ? 1'b1 : (vs_ph < 2);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    while ((m_cur >= 0 || m_any_pend()) && n < lim) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (n >= lim) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, lim);
    end
    idle_cycles(3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tone_en"}, bus.tone_en, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_tone_period"}, bus.tone_period, 0);
    check({tag, "_restart"}, bus.tone_restart, 0);
    check({tag, "_cur_event"}, bus.cur_event, 0);
  endtask

  initial begin
    int n;
    bus.vsync = 1'b0; bus.failure = 1'b0; bus.success = 1'b0; bus.eat = 1'b0; bus.tick = 1'b0;
    #2 rst_n = 1'b0;
    #1 mon_on = 1'b1;
    idle_cycles(4);
    check_zero("reset");
    rst_n = 1'b1;
    idle_cycles(5 * FRAME);
    check_zero("post_reset");

    // Single eat from IDLE.
    step(0, 0, 1, 0);
    wait_idle("eat", 2000);

    // Tick arriving while failure plays note 1 is dropped.
    step(1, 0, 0, 0);
    n = 0;
    while (!(m_cur == 3 && m_notes.size() == 2) && n < 500) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (n >= 500) begin
      n_vec++; n_err++;
      $display("FAIL fail_note1_timeout: note 1 not reached in %0d cycles", n);
    end
    step(0, 0, 0, 1);
    wait_idle("fail_tick", 2000);

    // Failure preempts eat during its first note.
    step(0, 0, 1, 0);
    idle_cycles(10);
    step(1, 0, 0, 0);
    wait_idle("preempt", 2000);

    // Success and eat together: success first, then eat.
    step(0, 1, 1, 0);
    wait_idle("succ_eat", 3000);

    // Asynchronous reset in the middle of a note.
    step(1, 0, 0, 0);
    idle_cycles(20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_tone_en", bus.tone_en, 0);
    check("async_busy", bus.busy, 0);
    check("async_tone_period", bus.tone_period, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Tick played while vsync is held high for 20 cycles: only one frame strobe.
    step(0, 0, 0, 1);
    vs_hold = 1'b1;
    idle_cycles(20);
    vs_hold = 1'b0;
    wait_idle("vs_hold", 2000);

    // Random event traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0);
    end
    wait_idle("random", 4000);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
